// File: rtl/soc_system_pio_pkg.sv
// Shared register map and helpers for the debounced button PIO.
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RAW          = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd5;

    localparam int unsigned MAX_WIDTH = 32;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input channel: synchroniser, optional debounce counter (SOC_PIO_DEBOUNCE_EN) and stable flop.
// update_o pulses combinationally on the edge where stable_o takes level_o.
module soc_system_pio_debounce
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic raw_o,
    output logic stable_o,
    output logic update_o,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    logic                   stable_q, stable_d;
    logic                   update;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
    assign sync   = sync_q[SYNC_STAGES-1];

`ifdef SOC_PIO_DEBOUNCE_EN
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Any sample equal to the stable level restarts the count.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        update   = 1'b0;
        if (sync != stable_q) begin
            if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync;
                update   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = sync;
        update   = (sync != stable_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
            stable_q <= IDLE_LEVEL;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
        end
    end

    assign raw_o    = sync;
    assign stable_o = stable_q;
    assign update_o = update;
    assign level_o  = stable_d;

    cfg_check: assert property (@(posedge clk) (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 1));

endmodule

// File: rtl/soc_system_button_pio_db.sv
// Avalon-MM button PIO with per-channel debounce (SOC_PIO_DEBOUNCE_EN), edge capture and masked irq.
module soc_system_button_pio_db
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable, raw, update, level, set, w1c, wdata;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, rise_q, rise_d, fall_q, fall_d;
    logic [MAX_WIDTH-1:0] rdata_q, rdata_d;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        soc_system_pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL[i])
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .din_i   (in_port[i]),
            .raw_o   (raw[i]),
            .stable_o(stable[i]),
            .update_o(update[i]),
            .level_o (level[i])
        );
    end

    assign wr_en        = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        mask_d = mask_q;
        rise_d = rise_q;
        fall_d = fall_q;
        w1c    = '0;
        if (wr_en) begin
            case (address)
                ADDR_IRQ_MASK:     mask_d = wdata;
                ADDR_EDGE_CAPTURE: w1c    = wdata;
                ADDR_RISE_EN:      rise_d = wdata;
                ADDR_FALL_EN:      fall_d = wdata;
                default: ;
            endcase
        end
        // New events are OR-ed in after the clear so a same-cycle set is never lost.
        set   = update & ((level & rise_q) | (~level & fall_q));
        cap_d = (cap_q & ~w1c) | set;

        rdata_d = '0;
        case (address)
            ADDR_DATA:         rdata_d = MAX_WIDTH'(stable);
            ADDR_RAW:          rdata_d = MAX_WIDTH'(raw);
            ADDR_IRQ_MASK:     rdata_d = MAX_WIDTH'(mask_q);
            ADDR_EDGE_CAPTURE: rdata_d = MAX_WIDTH'(cap_q);
            ADDR_RISE_EN:      rdata_d = MAX_WIDTH'(rise_q);
            ADDR_FALL_EN:      rdata_d = MAX_WIDTH'(fall_q);
            default:           rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            cap_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '1;
            rdata_q <= '0;
        end else begin
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(cap_q & mask_q);

    cfg_check: assert property (@(posedge clk) (WIDTH >= 1) && (WIDTH <= MAX_WIDTH));

endmodule

// File: tb/tb_soc_system_button_pio_db.sv
// Randomised and directed bench for soc_system_button_pio_db against a behavioural model.
module tb_soc_system_button_pio_db;

    localparam int unsigned W = 4;
    localparam int unsigned S = 2;
    localparam int unsigned D = 4;
`ifdef SOC_PIO_DEBOUNCE_EN
    localparam int unsigned LAT = S + D;
`else
    localparam int unsigned LAT = S + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_system_button_pio_db #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    // Behavioural model: sync is the pin seen S edges ago; a level is accepted
    // after D consecutive sync samples disagree with the accepted level.
    logic [W-1:0] pin_hist[$];
    logic [W-1:0] m_sync, m_stable, m_mask, m_cap, m_rise, m_fall;
    int           run[W];
    logic [31:0]  m_rdata;
    logic         m_irq;

    task automatic model_step();
        logic [W-1:0] pre_sync, set, w1c;
        logic [31:0]  rd;
        logic         changed;
        if (reset) begin
            pin_hist.delete();
            m_sync = '1; m_stable = '1; m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '1;
            for (int i = 0; i < W; i++) run[i] = 0;
            m_rdata = '0;
        end else begin
            case (address)
                3'd0: rd = 32'(m_stable);
                3'd1: rd = 32'(m_sync);
                3'd2: rd = 32'(m_mask);
                3'd3: rd = 32'(m_cap);
                3'd4: rd = 32'(m_rise);
                3'd5: rd = 32'(m_fall);
                default: rd = 32'h0;
            endcase
            pre_sync = m_sync;
            set = '0;
            for (int i = 0; i < W; i++) begin
                changed = 1'b0;
`ifdef SOC_PIO_DEBOUNCE_EN
                if (pre_sync[i] != m_stable[i]) begin
                    run[i]++;
                    if (run[i] == int'(D)) begin
                        m_stable[i] = pre_sync[i];
                        run[i] = 0;
                        changed = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
`else
                if (pre_sync[i] != m_stable[i]) begin
                    m_stable[i] = pre_sync[i];
                    changed = 1'b1;
                end
`endif
                if (changed) set[i] = m_stable[i] ? m_rise[i] : m_fall[i];
            end
            w1c = '0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd2: m_mask = writedata[W-1:0];
                    3'd3: w1c    = writedata[W-1:0];
                    3'd4: m_rise = writedata[W-1:0];
                    3'd5: m_fall = writedata[W-1:0];
                    default: ;
                endcase
            end
            m_cap = (m_cap & ~w1c) | set;
            pin_hist.push_front(in_port);
            if (pin_hist.size() > S) pin_hist.pop_back();
            m_sync = (pin_hist.size() == S) ? pin_hist[S-1] : '1;
            m_rdata = rd;
        end
        m_irq = |(m_cap & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] exp_tab[8] = '{32'hF, 32'hF, 32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0};
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL reset_readdata got %h exp %h", readdata, 32'h0);
        end
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            checks++;
            if (readdata !== exp_tab[a]) begin
                errors++; $display("FAIL reset_reg addr=%0d got %h exp %h", a, readdata, exp_tab[a]);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b exp 0", irq);
        end
    endtask

    task automatic test_falling();
        int n = 0;
        wr(3'd2, 32'h1);
        address = 3'd0;
        in_port[0] = 1'b0;
        while (irq !== 1'b1 && n < 50) begin
            tick(); n++;
            checks++;
            if (readdata !== m_rdata || irq !== m_irq) begin
                errors++;
                $display("FAIL falling_track cyc=%0d got rd=%h irq=%b exp rd=%h irq=%b",
                         n, readdata, irq, m_rdata, m_irq);
            end
        end
        checks++;
        if (n != int'(LAT)) begin
            errors++; $display("FAIL falling_latency got %0d edges exp %0d", n, LAT);
        end
        rd(3'd3);
        checks++;
        if (readdata !== 32'h1) begin
            errors++; $display("FAIL falling_capture got %h exp %h", readdata, 32'h1);
        end
        rd(3'd0);
        checks++;
        if (readdata !== 32'hE) begin
            errors++; $display("FAIL falling_data got %h exp %h", readdata, 32'hE);
        end
        wr(3'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL w1c_irq got %b exp 0", irq);
        end
        rd(3'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL w1c_capture got %h exp %h", readdata, 32'h0);
        end
    endtask

    task automatic test_bounce();
        wr(3'd3, 32'hF);
        address = 3'd0;
        for (int k = 0; k < 5; k++) begin
            in_port[1] = (k == 1 || k == 3);
            repeat ((k == 4) ? 12 : 2) begin
                tick();
                checks++;
                if (readdata !== m_rdata || irq !== m_irq) begin
                    errors++;
                    $display("FAIL bounce_track k=%0d got rd=%h irq=%b exp rd=%h irq=%b",
                             k, readdata, irq, m_rdata, m_irq);
                end
            end
        end
        rd(3'd0);
        checks++;
        if (readdata !== 32'hC) begin
            errors++; $display("FAIL bounce_data got %h exp %h", readdata, 32'hC);
        end
        rd(3'd3);
        checks++;
        if (readdata !== 32'h2) begin
            errors++; $display("FAIL bounce_capture got %h exp %h", readdata, 32'h2);
        end
    endtask

    task automatic test_rise_only();
        wr(3'd3, 32'hF);
        wr(3'd4, 32'h4);
        wr(3'd5, 32'h0);
        address = 3'd3;
        in_port[2] = 1'b0;
        repeat (10) tick();
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL rise_press got %h exp %h", readdata, 32'h0);
        end
        in_port[2] = 1'b1;
        repeat (10) begin
            tick();
            checks++;
            if (readdata !== m_rdata) begin
                errors++; $display("FAIL rise_track got %h exp %h", readdata, m_rdata);
            end
        end
        rd(3'd3);
        checks++;
        if (readdata !== 32'h4) begin
            errors++; $display("FAIL rise_release got %h exp %h", readdata, 32'h4);
        end
    endtask

    task automatic test_w1c_collision();
        wr(3'd5, 32'hF);
        wr(3'd4, 32'h0);
        wr(3'd3, 32'hF);
        in_port[3] = 1'b0;
        address = 3'd0;
        repeat (LAT - 1) tick();
        wr(3'd3, 32'h8);
        rd(3'd3);
        checks++;
        if (readdata !== 32'h8) begin
            errors++; $display("FAIL w1c_collision got %h exp %h", readdata, 32'h8);
        end
    endtask

    task automatic test_reset_mid();
        in_port = '1;
        address = 3'd0;
        repeat (10) tick();
        in_port[0] = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(3'd0);
        checks++;
        if (readdata !== 32'hF) begin
            errors++; $display("FAIL reset_mid_data got %h exp %h", readdata, 32'hF);
        end
        rd(3'd3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_capture got %h exp %h", readdata, 32'h0);
        end
        address = 3'd0;
        repeat (LAT + 2) begin
            tick();
            checks++;
            if (readdata !== m_rdata || irq !== m_irq) begin
                errors++;
                $display("FAIL reset_mid_track got rd=%h irq=%b exp rd=%h irq=%b",
                         readdata, irq, m_rdata, m_irq);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) in_port[$urandom_range(W-1)] ^= 1'b1;
            address = 3'($urandom_range(7));
            if ($urandom_range(5) == 0) begin
                chipselect = 1'b1; write_n = 1'b0; writedata = $urandom();
            end else begin
                chipselect = 1'($urandom_range(1)); write_n = 1'b1;
            end
            tick();
            checks++;
            if (readdata !== m_rdata || irq !== m_irq) begin
                errors++;
                $display("FAIL random cyc=%0d got rd=%h irq=%b exp rd=%h irq=%b",
                         c, readdata, irq, m_rdata, m_irq);
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '1;
        test_reset();
        test_falling();
        test_bounce();
        test_rise_only();
        test_w1c_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
